// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu -- rv32i execute stage with operand forwarding and an
// iterative RV32M multiply/divide unit.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   *_DE inputs         : ID/EX pipeline register contents
//   FWD1_SEL/FWD2_SEL   : forwarding select (0/3 = RF, 1 = EX/MEM, 2 = MEM/WB)
//   FWD_EM_VAL/_MW_VAL  : forwarded values from EX/MEM and MEM/WB
//   FLUSH_E             : kill the instruction in EX
//   ALU_VAL_E           : ALU, shifter or M-extension result
//   STORE_VAL_E         : forwarded rs2 for stores
//   isBranch_E/PC_IMM_E : branch decision and target
//   VALID_E             : result valid this cycle
//   STALL_E             : hold IF/ID/EX while the M unit is busy
module ex_stage_mdu #(
  parameter int XLEN             = 32,
  parameter int MUL_LAT          = 2,
  parameter int FAST_DIV_SPECIAL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            VALID_DE,
  input  logic [XLEN-1:0] PC_DE,
  input  logic            ALUSrc_DE,
  input  logic [4:0]      ALUOp_DE,
  input  logic            Branch_DE,
  input  logic            ALUorSHIFT_DE,
  input  logic [2:0]      FT_DE,
  input  logic            MD_DE,
  input  logic [2:0]      MDOp_DE,
  input  logic [XLEN-1:0] RF_DATA1_DE,
  input  logic [XLEN-1:0] RF_DATA2_DE,
  input  logic [XLEN-1:0] IMM_VAL_EXT_DE,
  input  logic            RS1_PC_DE,
  input  logic            RS1_Z_DE,
  input  logic [1:0]      FWD1_SEL,
  input  logic [1:0]      FWD2_SEL,
  input  logic [XLEN-1:0] FWD_EM_VAL,
  input  logic [XLEN-1:0] FWD_MW_VAL,
  input  logic            FLUSH_E,
  output logic [XLEN-1:0] ALU_VAL_E,
  output logic [XLEN-1:0] STORE_VAL_E,
  output logic            isBranch_E,
  output logic [XLEN-1:0] PC_IMM_E,
  output logic            VALID_E,
  output logic            STALL_E
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + MUL_LAT + 1);

  localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND = 5'd2,
                         ALU_OR   = 5'd3,  ALU_XOR  = 5'd4,  ALU_SLT = 5'd5,
                         ALU_SLTU = 5'd6,  ALU_EQ   = 5'd7,  ALU_NE  = 5'd8,
                         ALU_GE   = 5'd9,  ALU_GEU  = 5'd10, ALU_PASS2 = 5'd11,
                         ALU_SRL  = 5'd13, ALU_SRA  = 5'd14;
  localparam logic [2:0] FT_I = 3'd1, FT_B = 3'd3;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t r_state, w_next;

  logic [XLEN-1:0] w_src1, w_src2, w_data1, w_data2, w_alu, w_shift;
  logic [SW-1:0]   w_shamt;
  logic            w_take, w_launch;

  // forwarding muxes
  always_comb begin
    unique case (FWD1_SEL)
      2'd1:    w_src1 = FWD_EM_VAL;
      2'd2:    w_src1 = FWD_MW_VAL;
      default: w_src1 = RF_DATA1_DE;
    endcase
    unique case (FWD2_SEL)
      2'd1:    w_src2 = FWD_EM_VAL;
      2'd2:    w_src2 = FWD_MW_VAL;
      default: w_src2 = RF_DATA2_DE;
    endcase
  end

  assign w_data1 = RS1_PC_DE ? PC_DE : (RS1_Z_DE ? '0 : w_src1);
  assign w_data2 = ALUSrc_DE ? IMM_VAL_EXT_DE : w_src2;
  assign w_shamt = w_data2[SW-1:0];

  always_comb begin
    w_alu = '0;
    case (ALUOp_DE)
      ALU_ADD:   w_alu = w_data1 + w_data2;
      ALU_SUB:   w_alu = w_data1 - w_data2;
      ALU_AND:   w_alu = w_data1 & w_data2;
      ALU_OR:    w_alu = w_data1 | w_data2;
      ALU_XOR:   w_alu = w_data1 ^ w_data2;
      ALU_SLT:   w_alu = XLEN'($signed(w_data1) < $signed(w_data2));
      ALU_SLTU:  w_alu = XLEN'(w_data1 < w_data2);
      ALU_EQ:    w_alu = XLEN'(w_data1 == w_data2);
      ALU_NE:    w_alu = XLEN'(w_data1 != w_data2);
      ALU_GE:    w_alu = XLEN'($signed(w_data1) >= $signed(w_data2));
      ALU_GEU:   w_alu = XLEN'(w_data1 >= w_data2);
      ALU_PASS2: w_alu = w_data2;
      default:   w_alu = '0;
    endcase
  end

  always_comb begin
    case (ALUOp_DE)
      ALU_SRL: w_shift = w_data1 >> w_shamt;
      ALU_SRA: w_shift = XLEN'($signed(w_data1) >>> w_shamt);
      default: w_shift = w_data1 << w_shamt;
    endcase
  end

  assign PC_IMM_E = (FT_DE == FT_I) ? {w_alu[XLEN-1:1], 1'b0} : PC_DE + IMM_VAL_EXT_DE;
  assign w_take   = VALID_DE & ~MD_DE & ~FLUSH_E & Branch_DE &
                    ~((FT_DE == FT_B) & ~w_alu[0]);
  assign STORE_VAL_E = w_src2;

  // ---------------- M unit ----------------
  logic [XLEN-1:0] r_a, r_b, r_result, r_quo, r_rem, r_dvs, r_spec_val;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q, r_neg_r, r_is_rem, r_special;

  assign w_launch = (r_state == S_IDLE) & VALID_DE & MD_DE & ~FLUSH_E;

  // divide special cases, evaluated on live operands at launch
  logic            w_sgn, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_spec_val, w_abs1, w_abs2;
  assign w_sgn      = ~MDOp_DE[0];
  assign w_div0     = (w_src2 == '0);
  assign w_ovf      = w_sgn & (w_src1 == MIN_VAL) & (w_src2 == '1);
  assign w_special  = w_div0 | w_ovf;
  assign w_spec_val = w_div0 ? (MDOp_DE[1] ? w_src1 : '1) : (MDOp_DE[1] ? '0 : MIN_VAL);
  assign w_abs1     = (w_sgn & w_src1[XLEN-1]) ? -w_src1 : w_src1;
  assign w_abs2     = (w_sgn & w_src2[XLEN-1]) ? -w_src2 : w_src2;

  // multiplier inputs come straight from the operands in IDLE so MUL_LAT = 1
  // can register the result in the launch cycle
  logic [XLEN-1:0]   w_ma, w_mb, w_mul_res;
  logic [2:0]        w_mop;
  logic [2*XLEN-1:0] w_mxa, w_mxb, w_prod;
  assign w_ma  = (r_state == S_IDLE) ? w_src1  : r_a;
  assign w_mb  = (r_state == S_IDLE) ? w_src2  : r_b;
  assign w_mop = (r_state == S_IDLE) ? MDOp_DE : r_op;
  assign w_mxa = {{XLEN{(w_mop[1:0] != 2'b11) & w_ma[XLEN-1]}}, w_ma};
  assign w_mxb = {{XLEN{~w_mop[1] & w_mb[XLEN-1]}}, w_mb};
  assign w_prod = w_mxa * w_mxb;
  assign w_mul_res = (w_mop[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // one restoring step on magnitudes
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_div_res;
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_rem_nx  = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nx  = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
  assign w_div_res = r_special ? r_spec_val :
                     r_is_rem  ? (r_neg_r ? -w_rem_nx : w_rem_nx) :
                                 (r_neg_q ? -w_quo_nx : w_quo_nx);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_launch) begin
        if (!MDOp_DE[2]) w_next = (MUL_LAT == 1) ? S_DONE : S_MUL;
        else             w_next = ((FAST_DIV_SPECIAL != 0) && w_special) ? S_DONE : S_DIV;
      end
      S_MUL, S_DIV: begin
        if (FLUSH_E)                w_next = S_IDLE;
        else if (r_cnt == CW'(1))   w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0; r_b <= '0; r_op <= '0; r_cnt <= '0; r_result <= '0;
      r_quo <= '0; r_rem <= '0; r_dvs <= '0; r_spec_val <= '0;
      r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_is_rem <= 1'b0; r_special <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_launch) begin
          r_a        <= w_src1;
          r_b        <= w_src2;
          r_op       <= MDOp_DE;
          r_is_rem   <= MDOp_DE[1];
          r_neg_q    <= w_sgn & (w_src1[XLEN-1] ^ w_src2[XLEN-1]);
          r_neg_r    <= w_sgn & w_src1[XLEN-1];
          r_quo      <= w_abs1;
          r_rem      <= '0;
          r_dvs      <= w_abs2;
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          if (!MDOp_DE[2]) begin
            r_cnt <= CW'(MUL_LAT - 1);
            if (MUL_LAT == 1) r_result <= w_mul_res;
          end else begin
            r_cnt <= CW'(XLEN);
            if ((FAST_DIV_SPECIAL != 0) && w_special) r_result <= w_spec_val;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_result <= w_mul_res;
        end
        S_DIV: begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_result <= w_div_res;
        end
        default: ;
      endcase
    end
  end

  // outputs; reset forces the handshake outputs low even while DE holds an M op
  always_comb begin
    ALU_VAL_E  = ALUorSHIFT_DE ? w_shift : w_alu;
    VALID_E    = 1'b0;
    isBranch_E = 1'b0;
    STALL_E    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        STALL_E    = w_launch;
        VALID_E    = VALID_DE & ~MD_DE & ~FLUSH_E;
        isBranch_E = w_take;
      end
      S_MUL, S_DIV: STALL_E = ~FLUSH_E;
      S_DONE: begin
        ALU_VAL_E = r_result;
        VALID_E   = ~FLUSH_E;
      end
      default: ;
    endcase
    if (!rst_n) begin
      VALID_E    = 1'b0;
      isBranch_E = 1'b0;
      STALL_E    = 1'b0;
    end
  end

endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
Parametrised execute stage for the rv32i pipeline.
- Adds a 3-way operand forwarding mux on rs1 and rs2: register file, EX/MEM, MEM/WB.
- Adds an iterative RV32M multiply/divide unit that stalls the pipeline while busy.
- Integer ALU, shifter, branch-target and branch-decision paths stay single-cycle combinational.
- Sits between the ID/EX and EX/MEM pipeline registers; the hazard unit drives the FWD*_SEL inputs and consumes STALL_E.

Parameters:
- XLEN, 32, datapath width (8..64, power of two).
- MUL_LAT, 2, cycles from multiply launch to result (>=1).
- FAST_DIV_SPECIAL, 1, when 1, divide-by-zero and signed overflow finish one cycle after launch.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- VALID_DE  in  1  instruction in ID/EX is valid.
- PC_DE  in  XLEN  instruction PC.
- ALUSrc_DE  in  1  1 = immediate is operand 2.
- ALUOp_DE  in  5  ALU/shift opcode (alu.vh).
- Branch_DE  in  1  branch/jump instruction.
- ALUorSHIFT_DE  in  1  1 = select shifter result.
- FT_DE  in  3  format type (inst.vh FT_*).
- MD_DE  in  1  RV32M instruction.
- MDOp_DE  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- RF_DATA1_DE  in  XLEN  rs1 from register file.
- RF_DATA2_DE  in  XLEN  rs2 from register file.
- IMM_VAL_EXT_DE  in  XLEN  sign-extended immediate.
- RS1_PC_DE  in  1  operand 1 = PC.
- RS1_Z_DE  in  1  operand 1 = 0.
- FWD1_SEL  in  2  rs1 source: 0 = RF, 1 = EX/MEM, 2 = MEM/WB, 3 = RF.
- FWD2_SEL  in  2  rs2 source, same encoding.
- FWD_EM_VAL  in  XLEN  EX/MEM forward value.
- FWD_MW_VAL  in  XLEN  MEM/WB forward value.
- FLUSH_E  in  1  kill the instruction in EX.
- ALU_VAL_E  out  XLEN  result: ALU, shift or M-extension.
- STORE_VAL_E  out  XLEN  forwarded rs2.
- isBranch_E  out  1  take branch/jump.
- PC_IMM_E  out  XLEN  branch target.
- VALID_E  out  1  result valid this cycle.
- STALL_E  out  1  hold IF/ID/EX (DE registers must stay stable).

Behaviour:
- Forwarding
  - src1 = FWD mux on RF_DATA1_DE; src2 likewise on RF_DATA2_DE.
  - data1 priority: RS1_PC_DE, then RS1_Z_DE, then src1.
  - STORE_VAL_E = src2; data2 = ALUSrc_DE ? IMM : src2.
  - Shift amount = low log2(XLEN) bits of data2.
- Non-M path (MD_DE = 0), zero latency
  - ALU_VAL_E = ALUorSHIFT_DE ? shift : alu.
  - VALID_E = VALID_DE & ~FLUSH_E.
- Branch
  - PC_IMM_E = (FT_DE == FT_I) ? {alu[XLEN-1:1], 0} : PC_DE + IMM.
  - isBranch_E = VALID_DE & ~MD_DE & ~FLUSH_E & Branch_DE & ~(FT_DE == FT_B & ~alu[0]).
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE
  - VALID_DE & MD_DE & ~FLUSH_E launches: src1, src2 and MDOp are captured into internal registers.
  - MUL ops go to MUL; DIV/REM ops go to DIV.
  - STALL_E = 1 combinationally in the launch cycle.
- MUL
  - Counter runs MUL_LAT-1 cycles, then DONE. With MUL_LAT = 1, go straight to DONE.
  - Computes a 2*XLEN-bit product; signedness follows funct3.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DIV
  - Restoring radix-2 on magnitudes, XLEN iterations, then DONE.
  - Signs are applied at DONE: quotient is negative when operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
  - With FAST_DIV_SPECIAL = 1, both special cases skip the iterations and go to DONE on the next edge.
- DONE
  - ALU_VAL_E = registered M result; VALID_E = 1; STALL_E = 0; isBranch_E = 0.
  - Next state IDLE. In that IDLE cycle the DE-stage instruction is a new one and is not re-launched.
- STALL_E is 1 in the launch cycle and in every MUL/DIV cycle; 0 otherwise.
- Latency: launch in cycle k gives the result in cycle k+MUL_LAT (multiply), k+XLEN+1 (divide), k+1 (fast special case).
- FLUSH_E
  - In MUL or DIV: next state IDLE and STALL_E drops immediately.
  - In DONE: VALID_E is suppressed.
- VALID_DE = 0 in IDLE: no launch; VALID_E = 0.
- Reset (any time, including mid-divide)
  - FSM returns to IDLE; counters and result registers clear to 0.
  - STALL_E = 0, VALID_E = 0, isBranch_E = 0.
  - ALU_VAL_E follows the combinational path.

Test Plan:
- Forwarding: RF_DATA1 = 5, FWD_EM_VAL = 7, FWD1_SEL = 1, ADD with IMM = 3, ALUSrc = 1 -> ALU_VAL_E = 10 in the same cycle. With FWD2_SEL = 2 and FWD_MW_VAL = 0x55, STORE_VAL_E = 0x55.
- MUL/MULH: -3 * 4 (MUL) -> 0xFFFFFFF4. MULHU 0xFFFFFFFF * 2 -> 1. STALL_E is high for exactly MUL_LAT cycles and VALID_E pulses once.
- DIV/REM: -7 / 2 -> quotient 0xFFFFFFFD, REM -1. Result appears in cycle k+33 with STALL_E high for 33 cycles.
- Divide corners: DIVU x / 0 -> 0xFFFFFFFF; REM 9 % 0 -> 9; DIV 0x80000000 / -1 -> 0x80000000, REM 0. Each completes at k+1.
- Flush/reset: FLUSH_E at divide cycle 10 -> IDLE next edge, no VALID_E. rst_n low mid-multiply -> STALL_E = 0 immediately; a later MUL computes correctly.
- Branch: BEQ with equal operands, PC = 0x100, IMM = 0x20 -> isBranch_E = 1, PC_IMM_E = 0x120. JALR rs1 = 0x203, IMM = 0 -> target 0x202.
